// File: rtl/frame24_wrap.sv
// frame24_wrap: store-and-forward framer for the 24-bit gearbox word stream.
// It buffers each complete input frame and then sends it out as a header
// word, the payload words and a trailer word, using valid/ready.
//   clk128          system clock, rising edge
//   init_n          asynchronous active-low reset
//   datin/davin     input word and its single-cycle valid strobe
//   fstin/lstin     first/last word markers, qualified by davin
//   datout/davout   output word and valid; a transfer happens on davout & rdyin
//   fstout/lstout   high with the header word / with the trailer word
//   rdyin           downstream ready
//   dropcnt         frames dropped because the descriptor queue was full (saturates)
module frame24_wrap #(
  parameter int         DEPTH   = 512,
  parameter int         MAXLEN  = 1023,
  parameter int         NDESC   = 4,
  parameter logic [6:0] HDR_TAG = 7'h5A,
  parameter logic [7:0] TRL_TAG = 8'hC3
) (
  input  logic        clk128,
  input  logic        init_n,
  input  logic [23:0] datin,
  input  logic        davin,
  input  logic        fstin,
  input  logic        lstin,
  output logic [23:0] datout,
  output logic        davout,
  output logic        fstout,
  output logic        lstout,
  input  logic        rdyin,
  output logic [15:0] dropcnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(NDESC);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_HDR, R_PAY, R_TRL} rstate_t;

  // write side
  wstate_t     wstate_reg, wstate_next;
  logic [15:0] cnt_reg, cnt_next, csum_reg, csum_next;
  logic        ovf_reg, ovf_next;
  logic [AW:0] wptr_reg, cptr_reg;
  logic        mem_we, buf_full, start_req, closing, q_full, drop_inc;
  logic [15:0] dropcnt_reg;

  // descriptor queue: {ovf, count, checksum}
  logic [DW:0]   dwr_reg, dvis_reg, drd_reg, occ, avail;
  logic [DW-1:0] dwr_b, drd_b;
  logic          push_a, push_b;
  logic [32:0]   push_a_d, push_b_d;
  logic [32:0]   desc_q [NDESC];

  // read side
  rstate_t     rstate_reg, rstate_next;
  logic [15:0] hcnt_reg, hcnt_next, hcsum_reg, hcsum_next, pcnt_reg, pcnt_next;
  logic        hovf_reg, hovf_next;
  logic        load_desc, rd_pop, cptr_inc;
  logic [32:0] load_d;
  logic [AW-1:0] addr_sel;

  logic [23:0] mem [DEPTH];
  logic [23:0] ram_q;

  // Space is measured against the committed (transferred) read pointer.
  assign buf_full = ((wptr_reg - cptr_reg) == (AW+1)'(DEPTH));
  // occ includes the frame currently being sent: its slot is held until the trailer goes.
  assign occ      = dwr_reg - drd_reg;
  // avail lags the write pointer by one clock so a new descriptor is seen one cycle after the push.
  assign avail    = dvis_reg - drd_reg;
  assign dwr_b    = dwr_reg[DW-1:0] + DW'(1);
  assign drd_b    = drd_reg[DW-1:0] + DW'(1);
  assign dropcnt  = dropcnt_reg;

  always_comb begin
    wstate_next = wstate_reg;
    cnt_next    = cnt_reg;
    csum_next   = csum_reg;
    ovf_next    = ovf_reg;
    mem_we      = 1'b0;
    push_a      = 1'b0;
    push_b      = 1'b0;
    push_a_d    = '0;
    push_b_d    = '0;
    drop_inc    = 1'b0;
    start_req   = 1'b0;
    closing     = 1'b0;
    q_full      = 1'b0;
    case (wstate_reg)
      W_IDLE: if (davin && fstin) start_req = 1'b1;
      W_FILL: begin
        if (davin) begin
          if (fstin) begin
            // Unterminated frame: close it as overflowed, the word starts the next frame.
            push_a   = 1'b1;
            push_a_d = {1'b1, cnt_reg, csum_reg};
            closing  = 1'b1;
            start_req = 1'b1;
          end else begin
            if ((cnt_reg < 16'(MAXLEN)) && !buf_full) begin
              mem_we    = 1'b1;
              cnt_next  = cnt_reg + 16'd1;
              csum_next = csum_reg + datin[15:0];
            end else begin
              ovf_next = 1'b1;
            end
            if (lstin) begin
              push_a      = 1'b1;
              push_a_d    = {ovf_next, cnt_next, csum_next};
              wstate_next = W_IDLE;
            end
          end
        end
      end
      W_DROP: begin
        if (davin) begin
          if (fstin) start_req = 1'b1;
          else if (lstin) wstate_next = W_IDLE;
        end
      end
      default: wstate_next = W_IDLE;
    endcase

    if (start_req) begin
      // The slot of a frame closed in this same cycle already counts as used.
      q_full = closing ? (occ >= (DW+1)'(NDESC - 1)) : (occ >= (DW+1)'(NDESC));
      if (q_full) begin
        drop_inc    = 1'b1;
        wstate_next = lstin ? W_IDLE : W_DROP;
      end else begin
        if (!buf_full) begin
          mem_we    = 1'b1;
          cnt_next  = 16'd1;
          csum_next = datin[15:0];
          ovf_next  = 1'b0;
        end else begin
          cnt_next  = '0;
          csum_next = '0;
          ovf_next  = 1'b1;
        end
        if (lstin) begin
          if (closing) begin
            push_b   = 1'b1;
            push_b_d = {ovf_next, cnt_next, csum_next};
          end else begin
            push_a   = 1'b1;
            push_a_d = {ovf_next, cnt_next, csum_next};
          end
          wstate_next = W_IDLE;
        end else begin
          wstate_next = W_FILL;
        end
      end
    end
  end

  always_comb begin
    rstate_next = rstate_reg;
    hcnt_next   = hcnt_reg;
    hovf_next   = hovf_reg;
    hcsum_next  = hcsum_reg;
    pcnt_next   = pcnt_reg;
    cptr_inc    = 1'b0;
    rd_pop      = 1'b0;
    load_desc   = 1'b0;
    load_d      = desc_q[drd_reg[DW-1:0]];
    datout      = '0;
    davout      = 1'b0;
    fstout      = 1'b0;
    lstout      = 1'b0;
    case (rstate_reg)
      R_IDLE: if (avail != '0) load_desc = 1'b1;
      R_HDR: begin
        davout = 1'b1;
        fstout = 1'b1;
        datout = {HDR_TAG, hovf_reg, hcnt_reg};
        if (rdyin) begin
          pcnt_next   = hcnt_reg;
          rstate_next = (hcnt_reg == 16'd0) ? R_TRL : R_PAY;
        end
      end
      R_PAY: begin
        davout = 1'b1;
        datout = ram_q;
        if (rdyin) begin
          cptr_inc  = 1'b1;
          pcnt_next = pcnt_reg - 16'd1;
          if (pcnt_reg == 16'd1) rstate_next = R_TRL;
        end
      end
      R_TRL: begin
        davout = 1'b1;
        lstout = 1'b1;
        datout = {TRL_TAG, hcsum_reg};
        if (rdyin) begin
          rd_pop      = 1'b1;
          rstate_next = R_IDLE;
          // The head entry is the frame just finished; the next one sits behind it.
          if (avail >= (DW+1)'(2)) begin
            load_desc = 1'b1;
            load_d    = desc_q[drd_b];
          end
        end
      end
      default: rstate_next = R_IDLE;
    endcase
    if (load_desc) begin
      {hovf_next, hcnt_next, hcsum_next} = load_d;
      rstate_next = R_HDR;
    end
  end

  // The RAM address already points at the word that will be at the head after
  // this edge, so ram_q always holds the current payload word (1 word/clock).
  assign addr_sel = cptr_reg[AW-1:0] + AW'(cptr_inc);

  always_ff @(posedge clk128) begin
    if (mem_we) mem[wptr_reg[AW-1:0]] <= datin;
    ram_q <= mem[addr_sel];
  end

  genvar gi;
  for (gi = 0; gi < NDESC; gi++) begin : g_desc
    logic [32:0] ent_reg;
    always_ff @(posedge clk128 or negedge init_n) begin
      if (!init_n) ent_reg <= '0;
      else if (push_a && (dwr_reg[DW-1:0] == DW'(gi))) ent_reg <= push_a_d;
      else if (push_b && (dwr_b == DW'(gi))) ent_reg <= push_b_d;
    end
    assign desc_q[gi] = ent_reg;
  end

  always_ff @(posedge clk128 or negedge init_n) begin
    if (!init_n) begin
      wstate_reg  <= W_IDLE;
      cnt_reg     <= '0;
      csum_reg    <= '0;
      ovf_reg     <= 1'b0;
      wptr_reg    <= '0;
      cptr_reg    <= '0;
      dwr_reg     <= '0;
      dvis_reg    <= '0;
      drd_reg     <= '0;
      dropcnt_reg <= '0;
      rstate_reg  <= R_IDLE;
      hcnt_reg    <= '0;
      hcsum_reg   <= '0;
      hovf_reg    <= 1'b0;
      pcnt_reg    <= '0;
    end else begin
      wstate_reg <= wstate_next;
      cnt_reg    <= cnt_next;
      csum_reg   <= csum_next;
      ovf_reg    <= ovf_next;
      if (mem_we) wptr_reg <= wptr_reg + (AW+1)'(1);
      if (cptr_inc) cptr_reg <= cptr_reg + (AW+1)'(1);
      if (push_b) dwr_reg <= dwr_reg + (DW+1)'(2);
      else if (push_a) dwr_reg <= dwr_reg + (DW+1)'(1);
      dvis_reg <= dwr_reg;
      if (rd_pop) drd_reg <= drd_reg + (DW+1)'(1);
      if (drop_inc && (dropcnt_reg != 16'hFFFF)) dropcnt_reg <= dropcnt_reg + 16'd1;
      rstate_reg <= rstate_next;
      hcnt_reg   <= hcnt_next;
      hcsum_reg  <= hcsum_next;
      hovf_reg   <= hovf_next;
      pcnt_reg   <= pcnt_next;
    end
  end
endmodule

// File: tb/tb_frame24_wrap.sv
// tb_frame24_wrap: scoreboard bench for frame24_wrap (instantiated with MAXLEN=4).
// Expected output words are queued as stimulus is sent; a monitor collects
// every transfer and each test task pops and compares them.
module tb_frame24_wrap;
  logic        clk128 = 1'b0;
  logic        init_n;
  logic [23:0] datin;
  logic        davin, fstin, lstin;
  logic [23:0] datout;
  logic        davout, fstout, lstout;
  logic        rdyin;
  logic [15:0] dropcnt;

  int checks = 0;
  int failures = 0;

  logic [25:0] exp_q[$];
  logic [25:0] obs_q[$];
  logic [23:0] pay_q[$];

  frame24_wrap #(.DEPTH(512), .MAXLEN(4), .NDESC(4), .HDR_TAG(7'h5A), .TRL_TAG(8'hC3)) dut (
    .clk128 (clk128),
    .init_n (init_n),
    .datin  (datin),
    .davin  (davin),
    .fstin  (fstin),
    .lstin  (lstin),
    .datout (datout),
    .davout (davout),
    .fstout (fstout),
    .lstout (lstout),
    .rdyin  (rdyin),
    .dropcnt(dropcnt)
  );

  always #5 clk128 = ~clk128;

  // collect every transfer as {fst, lst, data}
  always @(negedge clk128) begin
    if (init_n && davout && rdyin) obs_q.push_back({fstout, lstout, datout});
  end

  task automatic send_word(input logic [23:0] d, input logic f, input logic l);
    datin = d; fstin = f; lstin = l; davin = 1'b1;
    @(posedge clk128); #1;
    davin = 1'b0; fstin = 1'b0; lstin = 1'b0;
  endtask

  // reference framing: header, payload words, trailer with 16-bit sum
  task automatic exp_frame(input logic ovf);
    logic [15:0] s;
    s = 16'd0;
    exp_q.push_back({2'b10, 7'h5A, ovf, 16'(pay_q.size())});
    foreach (pay_q[i]) begin
      exp_q.push_back({2'b00, pay_q[i]});
      s = s + pay_q[i][15:0];
    end
    exp_q.push_back({2'b01, 8'hC3, s});
    pay_q.delete();
  endtask

  task automatic wait_obs(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (obs_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk128);
    end
  endtask

  task automatic test_reset;
    init_n = 1'b0; rdyin = 1'b0; davin = 1'b0; fstin = 1'b0; lstin = 1'b0; datin = '0;
    repeat (3) @(posedge clk128);
    @(negedge clk128);
    checks++; if (davout !== 1'b0) begin failures++; $display("FAIL reset_davout: got %b required 0", davout); end
    checks++; if (fstout !== 1'b0) begin failures++; $display("FAIL reset_fstout: got %b required 0", fstout); end
    checks++; if (lstout !== 1'b0) begin failures++; $display("FAIL reset_lstout: got %b required 0", lstout); end
    checks++; if (datout !== 24'h0) begin failures++; $display("FAIL reset_datout: got %h required 000000", datout); end
    checks++; if (dropcnt !== 16'h0) begin failures++; $display("FAIL reset_dropcnt: got %h required 0000", dropcnt); end
    $display("reset: outputs idle, dropcnt=%0d", dropcnt);
    init_n = 1'b1;
    @(posedge clk128); #1;
  endtask

  task automatic test_basic;
    bit ok;
    logic [25:0] e, o;
    rdyin = 1'b1;
    pay_q.push_back(24'h000001); pay_q.push_back(24'h000002); pay_q.push_back(24'h000003);
    exp_frame(1'b0);
    send_word(24'h000001, 1'b1, 1'b0);
    send_word(24'h000002, 1'b0, 1'b0);
    send_word(24'h000003, 1'b0, 1'b1);
    @(negedge clk128);
    checks++; if (davout !== 1'b0) begin failures++; $display("FAIL basic_lat_n0: davout %b required 0", davout); end
    @(negedge clk128);
    checks++; if (davout !== 1'b0) begin failures++; $display("FAIL basic_lat_n1: davout %b required 0", davout); end
    @(negedge clk128);
    checks++; if ({davout, fstout} !== 2'b11) begin failures++; $display("FAIL basic_lat_n2: davout/fstout %b%b required 11", davout, fstout); end
    wait_obs(exp_q.size(), ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_timeout: got %0d words required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL basic_word: got %h required %h", o, e); end
      else $display("basic: fst=%b lst=%b dat=%h", o[25], o[24], o[23:0]);
    end
    exp_q.delete();
  endtask

  task automatic test_stall;
    bit ok;
    bit seen;
    logic [25:0] e, o;
    rdyin = 1'b1;
    pay_q.push_back(24'h000001); pay_q.push_back(24'h000002); pay_q.push_back(24'h000003);
    exp_frame(1'b0);
    send_word(24'h000001, 1'b1, 1'b0);
    send_word(24'h000002, 1'b0, 1'b0);
    send_word(24'h000003, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk128);
      if (davout && fstout) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL stall_header: got no header required header within 20 clocks"); end
    @(posedge clk128); #1; rdyin = 1'b1;
    @(posedge clk128); #1; rdyin = 1'b0;
    @(negedge clk128);
    checks++; if ({davout, datout} !== {1'b1, 24'h000002}) begin failures++; $display("FAIL stall_hold0: got %b/%h required 1/000002", davout, datout); end
    @(posedge clk128); #1; rdyin = 1'b0;
    @(negedge clk128);
    checks++; if ({davout, datout} !== {1'b1, 24'h000002}) begin failures++; $display("FAIL stall_hold1: got %b/%h required 1/000002", davout, datout); end
    @(posedge clk128); #1; rdyin = 1'b1;
    wait_obs(exp_q.size(), ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_timeout: got %0d words required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL stall_word: got %h required %h", o, e); end
      else $display("stall: fst=%b lst=%b dat=%h", o[25], o[24], o[23:0]);
    end
    exp_q.delete();
  endtask

  task automatic test_overflow;
    bit ok;
    logic [25:0] e, o;
    rdyin = 1'b1;
    for (int i = 0; i < 4; i++) pay_q.push_back(24'h000010 + 24'(i));
    exp_frame(1'b1);
    for (int i = 0; i < 6; i++) send_word(24'h000010 + 24'(i), (i == 0), (i == 5));
    wait_obs(exp_q.size(), ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_timeout: got %0d words required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL ovf_word: got %h required %h", o, e); end
      else $display("overflow: fst=%b lst=%b dat=%h", o[25], o[24], o[23:0]);
    end
    exp_q.delete();
  endtask

  task automatic test_missing_lst;
    bit ok;
    logic [25:0] e, o;
    rdyin = 1'b1;
    pay_q.push_back(24'h000011); exp_frame(1'b1);
    pay_q.push_back(24'h000022); exp_frame(1'b0);
    send_word(24'h000011, 1'b1, 1'b0);
    send_word(24'h000022, 1'b1, 1'b1);
    wait_obs(exp_q.size(), ok);
    checks++; if (!ok) begin failures++; $display("FAIL nolst_timeout: got %0d words required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL nolst_word: got %h required %h", o, e); end
      else $display("missing_lst: fst=%b lst=%b dat=%h", o[25], o[24], o[23:0]);
    end
    exp_q.delete();
  endtask

  task automatic test_desc_full;
    bit ok;
    logic [25:0] e, o;
    repeat (5) @(posedge clk128);
    #1; rdyin = 1'b0;
    for (int i = 0; i < 5; i++) send_word(24'h000100 + 24'(i), 1'b1, 1'b1);
    @(negedge clk128);
    checks++; if (dropcnt !== 16'd1) begin failures++; $display("FAIL desc_dropcnt: got %0d required 1", dropcnt); end
    for (int i = 0; i < 4; i++) begin
      pay_q.push_back(24'h000100 + 24'(i));
      exp_frame(1'b0);
    end
    @(posedge clk128); #1; rdyin = 1'b1;
    wait_obs(exp_q.size(), ok);
    checks++; if (!ok) begin failures++; $display("FAIL desc_timeout: got %0d words required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL desc_word: got %h required %h", o, e); end
      else $display("desc_full: fst=%b lst=%b dat=%h", o[25], o[24], o[23:0]);
    end
    exp_q.delete();
    repeat (20) @(negedge clk128);
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL desc_extra: got %0d extra words required 0", obs_q.size()); end
    obs_q.delete();
    checks++; if (dropcnt !== 16'd1) begin failures++; $display("FAIL desc_dropcnt_hold: got %0d required 1", dropcnt); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit seen;
    logic [25:0] e, o;
    rdyin = 1'b1;
    for (int i = 0; i < 4; i++) send_word(24'h000031 + 24'(i), (i == 0), (i == 3));
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk128);
      if (davout && !fstout && !lstout) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL rmid_pay: got no payload word required one within 20 clocks"); end
    init_n = 1'b0;
    #1;
    checks++; if ({davout, fstout, lstout} !== 3'b000) begin failures++; $display("FAIL rmid_strobes: got %b%b%b required 000", davout, fstout, lstout); end
    checks++; if (datout !== 24'h0) begin failures++; $display("FAIL rmid_datout: got %h required 000000", datout); end
    checks++; if (dropcnt !== 16'd0) begin failures++; $display("FAIL rmid_dropcnt: got %0d required 0", dropcnt); end
    $display("reset_mid: outputs cleared during payload");
    obs_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk128);
    init_n = 1'b1;
    @(posedge clk128); #1;
    pay_q.push_back(24'h000041); pay_q.push_back(24'h000042);
    exp_frame(1'b0);
    send_word(24'h000041, 1'b1, 1'b0);
    send_word(24'h000042, 1'b0, 1'b1);
    wait_obs(exp_q.size(), ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_timeout: got %0d words required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL rmid_word: got %h required %h", o, e); end
      else $display("reset_mid: fst=%b lst=%b dat=%h", o[25], o[24], o[23:0]);
    end
    exp_q.delete();
    checks++; if (dropcnt !== 16'd0) begin failures++; $display("FAIL rmid_dropcnt_after: got %0d required 0", dropcnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_missing_lst();
    test_desc_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frame24_wrap.md
Name: frame24_wrap

Overview:
- Store-and-forward framer placed directly downstream of the 16-to-24 gearbox. It consumes that stage's 24-bit word stream (dav/fst/lst strobes, no backpressure).
- Each complete frame is buffered, then re-emitted toward the link serializer as: header word, payload words, trailer word.
- The header carries the word count and an overflow flag. The trailer carries a 16-bit checksum.
- The output side uses a valid/ready handshake so the serializer can stall.

Parameters:
- DEPTH, 512, payload buffer depth in 24-bit words (power of 2).
- MAXLEN, 1023, maximum payload words stored per frame.
- NDESC, 4, frame-descriptor queue depth (power of 2).
- HDR_TAG, 7'h5A, header tag, bits [23:17].
- TRL_TAG, 8'hC3, trailer tag, bits [23:16].

Ports:
- clk128  in  1  system clock; all logic on rising edge.
- init_n  in  1  asynchronous active-low reset.
- datin  in  24  input word.
- davin  in  1  input word valid; single-cycle, any spacing.
- fstin  in  1  first word of frame; qualified by davin.
- lstin  in  1  last word of frame; qualified by davin.
- datout  out  24  output word.
- davout  out  1  output valid.
- fstout  out  1  high with the header word.
- lstout  out  1  high with the trailer word.
- rdyin  in  1  downstream ready; transfer occurs when davout & rdyin.
- dropcnt  out  16  count of frames dropped because the descriptor queue was full; saturates at 16'hFFFF.

Behaviour:
- Reset (init_n low, asynchronous): all outputs 0 and dropcnt 0. The buffer is emptied, the descriptor queue is emptied, and the write FSM enters IDLE.
- If reset asserts mid-frame or mid-output, partial data is discarded and no trailer is sent.

Write side FSM:
- States: IDLE, FILL, DROP.
- IDLE:
  - davin&fstin with descriptor queue not full: store the word, count=1, start checksum, go to FILL.
  - davin&fstin with queue full: increment dropcnt, go to DROP.
  - davin without fstin: discarded.
- FILL: each davin word is stored if count<MAXLEN and the buffer is not full. Otherwise the word is discarded and ovf=1.
- Frame close: davin&lstin closes the frame and pushes descriptor {count, ovf, checksum}; FSM returns to IDLE.
- fstin&lstin on the same word: single-word frame, count=1, pushed immediately.
- fstin while in FILL:
  - The current frame is closed without storing that word, with ovf=1.
  - The new word then starts a new frame in the same cycle, applying the IDLE rules; the descriptor slot is freed only after the push.
- DROP: discard all words through lstin, then go to IDLE. A fstin seen during DROP is treated as in IDLE.
- Checksum: 16-bit sum, mod 2^16, of datin[15:0] over stored payload words only.
- count is 16 bits and counts stored words only.

Read side FSM:
- States: RIDLE, HDR, PAY, TRL.
- RIDLE: when the descriptor queue is non-empty, pop a descriptor and go to HDR.
- HDR: present datout={HDR_TAG, ovf, count[15:0]}, davout=1, fstout=1. After the transfer, go to PAY.
- PAY: present buffered words in order, davout=1. After count transfers, go to TRL.
- TRL: present datout={TRL_TAG, checksum}, davout=1, lstout=1. After the transfer, go to RIDLE.
- Back-to-back frames: the next header may follow the trailer on the next clock if a descriptor is queued.
- Latency: lstin sampled at edge N, descriptor valid after N+1, header davout high after edge N+2. This assumes the read side is idle.
- Stall hold: while davout & !rdyin, datout, fstout and lstout are held stable and davout stays high.
- The buffer is read via a registered read pointer plus a one-word prefetch register. Payload must stream at 1 word/clock when rdyin is held high.
- Buffer full: computed from write pointer minus committed read pointer. Space is reclaimed as words are transferred.
- Writing and reading the buffer on the same clock is legal.

Test Plan:
- Basic frame: fst word 24'h000001, then 24'h000002, then lst word 24'h000003; rdyin=1. Required output: 24'hB40003 (fstout), then 000001, 000002, 000003, then 24'hC30006 (lstout). Header appears 2 clocks after the lstin edge.
- Stall: same frame with rdyin toggled 1,0,0,1 during payload. datout must hold 000002 through the stall cycles; no duplicated or lost words.
- Overflow: MAXLEN=4 with 6 words sent. Header must be 24'hB50004; only words 1–4 appear; checksum covers those 4 words only.
- Missing lst: fst, w1, fst, w2 lst. Required output is two frames: header B50001 then w1, followed by header B40001 then w2, each with correct trailers.
- Descriptor full: rdyin=0 with 5 single-word frames sent (NDESC=4). dropcnt must read 1. After rdyin=1, exactly 4 frames are emitted.
- Reset mid-output: drive init_n low during PAY. All outputs must be 0 immediately. After release, a new frame is emitted cleanly with dropcnt=0.
